// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: decode-side reads/alloc and writeback-side commits.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 4,
  parameter int NWP  = 2
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [NRP*AW-1:0]   rd_addr_i;
  logic [NRP*XLEN-1:0] rd_data_o;
  logic [NRP-1:0]      rd_busy_o;
  logic [NWP-1:0]      wr_en_i;
  logic [NWP*AW-1:0]   wr_addr_i;
  logic [NWP*XLEN-1:0] wr_data_i;
  logic                alloc_en_i;
  logic [AW-1:0]       alloc_addr_i;
  logic [CW-1:0]       busy_cnt_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i,
    input  rd_data_o, rd_busy_o, busy_cnt_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, alloc_en_i, alloc_addr_i,
    output rd_data_o, rd_busy_o, busy_cnt_o
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard, x0 hardwired to zero,
// and optional same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRP    = 4,
  parameter int NWP    = 2,
  parameter bit BYPASS = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [XLEN-1:0]     r_regs [NREG];
  logic [NREG-1:0]     r_busy;
  logic [CW-1:0]       r_busyCnt;

  logic [NREG-1:0]     w_wrHit;
  logic [XLEN-1:0]     w_wrData [NREG];
  logic [NREG-1:0]     w_allocHit;
  logic [NREG-1:0]     w_busyNext;
  logic [CW-1:0]       w_clrCnt;
  logic                w_allocFresh;
  logic [NRP*XLEN-1:0] w_rdData;
  logic [NRP-1:0]      w_rdBusy;

  // Per-register decode of commits; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    w_wrHit    = '0;
    w_allocHit = '0;
    w_busyNext = '0;
    w_clrCnt   = '0;
    for (int r = 0; r < NREG; r++) begin
      w_wrData[r] = '0;
      for (int w = 0; w < NWP; w++) begin
        if (r != 0 && bus.wr_en_i[w] && bus.wr_addr_i[w*AW +: AW] == AW'(r)) begin
          w_wrHit[r]  = 1'b1;
          w_wrData[r] = bus.wr_data_i[w*XLEN +: XLEN];
        end
      end
      w_allocHit[r] = (r != 0) && bus.alloc_en_i && (bus.alloc_addr_i == AW'(r));
      w_busyNext[r] = w_allocHit[r] | (r_busy[r] & ~w_wrHit[r]);
      if (r_busy[r] && w_wrHit[r] && !w_allocHit[r])
        w_clrCnt = w_clrCnt + CW'(1);
    end
  end

  assign w_allocFresh = |(w_allocHit & ~r_busy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++)
        r_regs[r] <= '0;
      r_busy    <= '0;
      r_busyCnt <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        if (w_wrHit[r])
          r_regs[r] <= w_wrData[r];
      r_busy    <= w_busyNext;
      r_busyCnt <= r_busyCnt + CW'(w_allocFresh) - w_clrCnt;
    end
  end

  // A forwarded read reports not-busy unless a new producer is allocated in the same cycle.
  always_comb begin
    logic [AW-1:0] w_rdAddr;
    w_rdData = '0;
    w_rdBusy = '0;
    w_rdAddr = '0;
    for (int p = 0; p < NRP; p++) begin
      w_rdAddr = bus.rd_addr_i[p*AW +: AW];
      if (w_rdAddr != '0) begin
        w_rdData[p*XLEN +: XLEN] = r_regs[w_rdAddr];
        w_rdBusy[p]              = r_busy[w_rdAddr];
        if (BYPASS) begin
          for (int w = 0; w < NWP; w++) begin
            if (bus.wr_en_i[w] && bus.wr_addr_i[w*AW +: AW] == w_rdAddr) begin
              w_rdData[p*XLEN +: XLEN] = bus.wr_data_i[w*XLEN +: XLEN];
              w_rdBusy[p]              = bus.alloc_en_i && (bus.alloc_addr_i == w_rdAddr);
            end
          end
        end
      end
    end
  end

  assign bus.rd_data_o  = w_rdData;
  assign bus.rd_busy_o  = w_rdBusy;
  assign bus.busy_cnt_o = r_busyCnt;

`ifdef REGFILE_MP_SCOREBOARD_CHECK
  always @(posedge clk) begin
    if (rst_n) begin
      for (int w = 0; w < NWP; w++) begin
        if (bus.wr_en_i[w] && bus.wr_addr_i[w*AW +: AW] != '0 &&
            !r_busy[bus.wr_addr_i[w*AW +: AW]])
          $error("regfile_mp: write to non-busy register %0d", bus.wr_addr_i[w*AW +: AW]);
      end
    end
  end
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one forwarding and one non-forwarding instance share stimulus.
module tb_regfile_mp;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_mp_if #(.XLEN(32), .NREG(32), .NRP(4), .NWP(2)) bus1 ();
  regfile_mp_if #(.XLEN(32), .NREG(32), .NRP(4), .NWP(2)) bus0 ();

  regfile_mp #(.XLEN(32), .NREG(32), .NRP(4), .NWP(2), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  regfile_mp #(.XLEN(32), .NREG(32), .NRP(4), .NWP(2), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [1:0] wrEn, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic allocEn, input logic [4:0] allocAddr);
    bus1.wr_en_i = wrEn;  bus1.wr_addr_i = {wa1, wa0};  bus1.wr_data_i = {wd1, wd0};
    bus1.alloc_en_i = allocEn;  bus1.alloc_addr_i = allocAddr;
    bus0.wr_en_i = wrEn;  bus0.wr_addr_i = {wa1, wa0};  bus0.wr_data_i = {wd1, wd0};
    bus0.alloc_en_i = allocEn;  bus0.alloc_addr_i = allocAddr;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic setRead(input int port, input logic [4:0] addr);
    bus1.rd_addr_i[port*5 +: 5] = addr;
    bus0.rd_addr_i[port*5 +: 5] = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus1.rd_addr_i = '0;
    bus0.rd_addr_i = '0;
    idle();
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    tick();

    // Reset state: every register on every port reads zero and not busy
    checkOutput("rst_cnt_byp", 32'(bus1.busy_cnt_o), 32'd0);
    checkOutput("rst_cnt_nobyp", 32'(bus0.busy_cnt_o), 32'd0);
    for (int r = 0; r < 32; r++) begin
      for (int p = 0; p < 4; p++) setRead(p, 5'(r));
      #1;
      for (int p = 0; p < 4; p++) begin
        checkOutput($sformatf("rst_data_byp_x%0d_p%0d", r, p), bus1.rd_data_o[p*32 +: 32], 32'h0);
        checkOutput($sformatf("rst_data_nobyp_x%0d_p%0d", r, p), bus0.rd_data_o[p*32 +: 32], 32'h0);
        checkOutput($sformatf("rst_busy_x%0d_p%0d", r, p), 32'({bus1.rd_busy_o[p], bus0.rd_busy_o[p]}), 32'd0);
      end
    end
    tick();

    // Write x5 on port 0 while port 3 reads it
    applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0);
    setRead(3, 5'd5);
    #1;
    checkOutput("x5_same_byp", bus1.rd_data_o[96 +: 32], 32'hDEADBEEF);
    checkOutput("x5_same_nobyp", bus0.rd_data_o[96 +: 32], 32'h0);
    tick();
    idle();
    #1;
    checkOutput("x5_next_byp", bus1.rd_data_o[96 +: 32], 32'hDEADBEEF);
    checkOutput("x5_next_nobyp", bus0.rd_data_o[96 +: 32], 32'hDEADBEEF);

    // Two ports write x7; port 1 wins
    applyStimulus(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 1'b0, 5'd0);
    setRead(0, 5'd7);
    #1;
    checkOutput("x7_same_byp", bus1.rd_data_o[0 +: 32], 32'h22222222);
    tick();
    idle();
    #1;
    checkOutput("x7_byp", bus1.rd_data_o[0 +: 32], 32'h22222222);
    checkOutput("x7_nobyp", bus0.rd_data_o[0 +: 32], 32'h22222222);

    // Write and allocate x0
    applyStimulus(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd0);
    setRead(1, 5'd0);
    #1;
    checkOutput("x0_same_data", bus1.rd_data_o[32 +: 32], 32'h0);
    checkOutput("x0_same_busy", 32'(bus1.rd_busy_o[1]), 32'd0);
    tick();
    idle();
    #1;
    checkOutput("x0_data_byp", bus1.rd_data_o[32 +: 32], 32'h0);
    checkOutput("x0_data_nobyp", bus0.rd_data_o[32 +: 32], 32'h0);
    checkOutput("x0_busy", 32'({bus1.rd_busy_o[1], bus0.rd_busy_o[1]}), 32'd0);
    checkOutput("x0_cnt", 32'(bus1.busy_cnt_o), 32'd0);

    // Allocate x3, then x9, then write x3
    setRead(2, 5'd3);
    setRead(1, 5'd9);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3);
    tick();
    idle();
    #1;
    checkOutput("alloc3_cnt", 32'(bus1.busy_cnt_o), 32'd1);
    checkOutput("alloc3_busy", 32'({bus1.rd_busy_o[2], bus0.rd_busy_o[2]}), 32'b11);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9);
    tick();
    idle();
    #1;
    checkOutput("alloc9_cnt_byp", 32'(bus1.busy_cnt_o), 32'd2);
    checkOutput("alloc9_cnt_nobyp", 32'(bus0.busy_cnt_o), 32'd2);
    checkOutput("alloc9_busy", 32'({bus1.rd_busy_o[1], bus0.rd_busy_o[1]}), 32'b11);
    applyStimulus(2'b01, 5'd3, 32'hCAFE0003, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("wr3_same_busy_byp", 32'(bus1.rd_busy_o[2]), 32'd0);
    checkOutput("wr3_same_busy_nobyp", 32'(bus0.rd_busy_o[2]), 32'd1);
    checkOutput("wr3_same_data_byp", bus1.rd_data_o[64 +: 32], 32'hCAFE0003);
    checkOutput("wr3_same_data_nobyp", bus0.rd_data_o[64 +: 32], 32'h0);
    tick();
    idle();
    #1;
    checkOutput("wr3_cnt", 32'(bus1.busy_cnt_o), 32'd1);
    checkOutput("wr3_busy", 32'({bus1.rd_busy_o[2], bus0.rd_busy_o[2]}), 32'b00);
    checkOutput("wr3_data_nobyp", bus0.rd_data_o[64 +: 32], 32'hCAFE0003);
    checkOutput("wr3_x9_busy", 32'({bus1.rd_busy_o[1], bus0.rd_busy_o[1]}), 32'b11);
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'h99999999, 1'b0, 5'd0);
    tick();
    idle();
    #1;
    checkOutput("wr9_cnt", 32'(bus0.busy_cnt_o), 32'd0);
    checkOutput("wr9_data", bus0.rd_data_o[32 +: 32], 32'h99999999);

    // Allocate and write x4 in the same cycle: allocate wins, data stored
    setRead(0, 5'd4);
    applyStimulus(2'b01, 5'd4, 32'h44444444, 5'd0, 32'h0, 1'b1, 5'd4);
    #1;
    checkOutput("aw4_same_busy_byp", 32'(bus1.rd_busy_o[0]), 32'd1);
    checkOutput("aw4_same_data_byp", bus1.rd_data_o[0 +: 32], 32'h44444444);
    tick();
    idle();
    #1;
    checkOutput("aw4_busy", 32'({bus1.rd_busy_o[0], bus0.rd_busy_o[0]}), 32'b11);
    checkOutput("aw4_data", bus0.rd_data_o[0 +: 32], 32'h44444444);
    checkOutput("aw4_cnt", 32'(bus1.busy_cnt_o), 32'd1);

    // Re-allocating a busy register leaves the count alone
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4);
    tick();
    idle();
    #1;
    checkOutput("realloc4_cnt", 32'(bus1.busy_cnt_o), 32'd1);

    // Two busy registers cleared in one cycle
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd10);
    tick();
    idle();
    #1;
    checkOutput("alloc10_cnt", 32'(bus1.busy_cnt_o), 32'd2);
    applyStimulus(2'b11, 5'd4, 32'h40404040, 5'd10, 32'hA0A0A0A0, 1'b0, 5'd0);
    tick();
    idle();
    #1;
    checkOutput("dualclr_cnt_byp", 32'(bus1.busy_cnt_o), 32'd0);
    checkOutput("dualclr_cnt_nobyp", 32'(bus0.busy_cnt_o), 32'd0);
    checkOutput("dualclr_x4_data", bus0.rd_data_o[0 +: 32], 32'h40404040);

    // Asynchronous reset mid-operation
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4);
    tick();
    idle();
    #1;
    checkOutput("prerst_cnt", 32'(bus1.busy_cnt_o), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_cnt_byp", 32'(bus1.busy_cnt_o), 32'd0);
    checkOutput("arst_cnt_nobyp", 32'(bus0.busy_cnt_o), 32'd0);
    checkOutput("arst_busy", 32'({bus1.rd_busy_o[0], bus0.rd_busy_o[0]}), 32'b00);
    checkOutput("arst_data", bus0.rd_data_o[0 +: 32], 32'h0);
    checkOutput("arst_x5_data", bus1.rd_data_o[96 +: 32], 32'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("postrst_cnt", 32'(bus1.busy_cnt_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with per-register busy scoreboard, the next generation of the core's 2R/1W register file. It serves the decode stage (reads, busy checks, destination allocation) and the writeback stage (commits). It is intended for a dual-issue pipeline. Register 0 is hardwired to zero, and optional write-to-read bypass removes the writeback-to-decode hazard.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, ≥ 2
- AW, $clog2(NREG), register address width (derived, not overridden)
- NRP, 4, number of read ports
- NWP, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr_i  in  NRP*AW  read addresses; port p uses bits [p*AW +: AW]
- rd_data_o  out  NRP*XLEN  read data, port p at [p*XLEN +: XLEN]; combinational
- rd_busy_o  out  NRP  busy bit of the addressed register, per read port; combinational
- wr_en_i  in  NWP  write enables
- wr_addr_i  in  NWP*AW  write addresses
- wr_data_i  in  NWP*XLEN  write data
- alloc_en_i  in  1  mark a destination register as pending
- alloc_addr_i  in  AW  register to mark busy
- busy_cnt_o  out  $clog2(NREG+1)  number of registers currently busy; registered

## Operation
- Storage is NREG x XLEN flops plus an NREG-bit busy vector.
- On reset, every register is 0, every busy bit is 0, and busy_cnt_o is 0.
- Register 0:
  - Reads of address 0 return 0 and busy 0.
  - Writes to address 0 are ignored.
  - Allocations to address 0 are ignored.
- Write: when wr_en_i[w] is set and wr_addr_i[w] != 0, the register takes wr_data_i[w] at the clock edge, and its busy bit is cleared.
- Write-port conflict: if several enabled ports target the same register in one cycle, the highest-index port wins the data. Busy is cleared once.
- Allocate: when alloc_en_i is set and alloc_addr_i != 0, the busy bit is set at the clock edge.
- Allocate and write to the same register in the same cycle: allocate wins and busy ends at 1, because the new producer supersedes the old one. The write data is still stored.
- Allocate to an already busy register: busy stays 1 and busy_cnt_o does not change.
- Read with BYPASS=1:
  - If any enabled write port targets the read address (≠ 0) in the same cycle, rd_data_o returns that write data, using the highest-index matching port.
  - rd_busy_o for that port returns 0 unless alloc_en_i targets the same address in the same cycle, in which case it returns 1.
- Read with BYPASS=0: rd_data_o and rd_busy_o reflect the stored state only.
- Busy count:
  - busy_cnt_o equals the popcount of the busy vector after the edge. It is maintained incrementally: +1 for a fresh allocate, −1 for each register cleared.
  - It must never underflow or exceed NREG−1, since register 0 is never busy.
- Simulation-only: an $error fires if a write targets a non-busy register while a scoreboard-check define is set. Writes to non-busy registers remain legal in synthesis.

## Timing
- Read latency is 0 cycles: all read outputs are purely combinational from the addresses, the write/alloc inputs (when BYPASS=1) and the state.
- Write latency is 1 cycle: with BYPASS=0, data is visible on reads in the cycle after the edge.
- Busy set and clear take effect at the edge; rd_busy_o reflects them the next cycle, except for the bypass case described above.
- Reset is asynchronous: asserting rst_n mid-operation clears storage, busy bits and busy_cnt_o immediately. The first edge after deassertion processes inputs normally.
- There is no handshake: the caller guarantees inputs are stable around the clock edge. The block never stalls.

## Test plan
- Reset, then read all registers on all ports -> every rd_data_o = 0, rd_busy_o = 0, busy_cnt_o = 0.
- Write 0xDEADBEEF to x5 on port 0, and in the same cycle read x5 on port 3 -> with BYPASS=1 the read returns 0xDEADBEEF immediately; with BYPASS=0 it returns 0 first, then 0xDEADBEEF on the next cycle.
- Ports 0 and 1 both write x7, with 0x11111111 and 0x22222222 -> x7 reads 0x22222222.
- Write 0xFFFFFFFF to x0 and allocate x0 -> reads of x0 return 0 with busy 0, and busy_cnt_o stays 0.
- Allocate x3, then x9, then write x3:
  - busy_cnt_o steps 1, 2, 1.
  - rd_busy_o for x3 is 1 and then 0.
  - With BYPASS=1, the same-cycle read of x3 shows busy 0.
- Allocate x4 and write x4 in the same cycle -> busy stays 1, data updates, busy_cnt_o = 1. Then assert rst_n mid-sequence -> every busy bit clears and busy_cnt_o = 0 without waiting for a clock edge.
